// File: rtl/start_stop_intr_gen.sv
// Start/stop window interrupt generator: synchronises start and NSTOP stop pulses,
// tracks enabled stop hits inside a start-opened window and raises a stretched active-low interrupt.

module start_stop_intr_gen_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic res_n,
    input  logic din,
    output logic strobe
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Strobe is registered so the rise shows up SYNC_STAGES cycles after sampling.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            sync   <= '0;
            prev   <= 1'b0;
            strobe <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], din};
            prev   <= sync[SYNC_STAGES-1];
            strobe <= sync[SYNC_STAGES-1] & ~prev;
        end
    end
endmodule

module start_stop_intr_gen #(
    parameter int NSTOP       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int INTR_LEN    = 60
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             startpulse,
    input  logic [NSTOP-1:0] stoppulse,
    input  logic [NSTOP-1:0] en_mask,
    output logic             intr_n,
    output logic [NSTOP-1:0] hit_mask,
    output logic             timeout_flag,
    output logic             overrun,
    output logic             busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(INTR_LEN + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(INTR_LEN - 1);

    typedef enum logic [1:0] {IDLE, ARMED, INTR} state_t;

    state_t           state, state_nxt;
    logic [NSTOP:0]   strobe;
    logic             start_stb;
    logic [NSTOP-1:0] stop_stb;
    logic [NSTOP-1:0] en_lat, en_nxt;
    logic [NSTOP-1:0] work, work_nxt;
    logic [NSTOP-1:0] hits;
    logic             done_all;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic [IW-1:0]    icnt, icnt_nxt;
    logic [NSTOP-1:0] hit_nxt;
    logic             tflag_nxt;
    logic             overrun_nxt;

    // Lane NSTOP carries the start pulse, lanes 0..NSTOP-1 the stops.
    for (genvar g = 0; g <= NSTOP; g++) begin : g_lane
        start_stop_intr_gen_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .res_n  (res_n),
            .din    ((g == NSTOP) ? startpulse : stoppulse[g % NSTOP]),
            .strobe (strobe[g])
        );
    end

    assign start_stb = strobe[NSTOP];
    assign stop_stb  = strobe[NSTOP-1:0];
    assign hits      = work | (stop_stb & en_lat);
    assign done_all  = ((hits & en_lat) == en_lat);

    always_comb begin
        state_nxt   = state;
        en_nxt      = en_lat;
        work_nxt    = work;
        tcnt_nxt    = tcnt;
        icnt_nxt    = icnt;
        hit_nxt     = hit_mask;
        tflag_nxt   = timeout_flag;
        overrun_nxt = overrun | (start_stb && (state != IDLE));
        case (state)
            IDLE: begin
                if (start_stb) begin
                    state_nxt = ARMED;
                    en_nxt    = en_mask;
                    work_nxt  = '0;
                    tcnt_nxt  = '0;
                end
            end
            ARMED: begin
                work_nxt = hits;
                tcnt_nxt = tcnt + 1'b1;
                // All-stops-hit wins over a timeout landing in the same cycle.
                if (done_all || (tcnt == T_LAST)) begin
                    state_nxt = INTR;
                    hit_nxt   = hits;
                    tflag_nxt = ~done_all;
                    icnt_nxt  = '0;
                end
            end
            INTR: begin
                if (icnt == I_LAST) state_nxt = IDLE;
                else                icnt_nxt  = icnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state        <= IDLE;
            en_lat       <= '0;
            work         <= '0;
            tcnt         <= '0;
            icnt         <= '0;
            intr_n       <= 1'b1;
            hit_mask     <= '0;
            timeout_flag <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            en_lat       <= en_nxt;
            work         <= work_nxt;
            tcnt         <= tcnt_nxt;
            icnt         <= icnt_nxt;
            intr_n       <= (state_nxt != INTR);
            hit_mask     <= hit_nxt;
            timeout_flag <= tflag_nxt;
            overrun      <= overrun_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_start_stop_intr_gen.sv
// Bench for start_stop_intr_gen: directed scenarios plus random pulses, checked every
// cycle against a window/countdown model of the block.

module tb_start_stop_intr_gen;
    localparam int NSTOP = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 16;
    localparam int ILEN  = 60;

    logic             clk = 1'b0;
    logic             res_n = 1'b0;
    logic             startpulse = 1'b0;
    logic [NSTOP-1:0] stoppulse = '0;
    logic [NSTOP-1:0] en_mask = '0;
    logic             intr_n;
    logic [NSTOP-1:0] hit_mask;
    logic             timeout_flag;
    logic             overrun;
    logic             busy;

    always #5 clk = ~clk;

    start_stop_intr_gen #(.NSTOP(NSTOP), .SYNC_STAGES(SYNC), .TIMEOUT(TMO), .INTR_LEN(ILEN)) dut (
        .clk          (clk),
        .res_n        (res_n),
        .startpulse   (startpulse),
        .stoppulse    (stoppulse),
        .en_mask      (en_mask),
        .intr_n       (intr_n),
        .hit_mask     (hit_mask),
        .timeout_flag (timeout_flag),
        .overrun      (overrun),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
            end
        end
    endtask

    // Model: pulses are seen SYNC+1 edges after sampling as rises of the sampled history;
    // a window is "armed" for m_age cycles, then an interrupt countdown of ILEN cycles.
    logic [NSTOP:0]   hist [SYNC+2];
    bit               m_armed = 0;
    int               m_age = 0;
    int               m_intr_left = 0;
    logic [NSTOP-1:0] m_en = '0, m_work = '0, m_hit = '0;
    bit               m_tflag = 0, m_ovr = 0;
    bit               seen_reset = 0;

    always @(posedge clk) begin : model
        logic [NSTOP:0]   stb;
        logic [NSTOP-1:0] s_stop;
        bit               s_start;
        if (!res_n) begin
            for (int i = 0; i < SYNC + 2; i++) hist[i] = '0;
            m_armed = 0; m_age = 0; m_intr_left = 0;
            m_en = '0; m_work = '0; m_hit = '0; m_tflag = 0; m_ovr = 0;
            seen_reset = 1;
        end else begin
            stb     = hist[SYNC] & ~hist[SYNC+1];
            s_start = stb[NSTOP];
            s_stop  = stb[NSTOP-1:0];
            if (m_intr_left > 0) begin
                if (s_start) m_ovr = 1;
                m_intr_left--;
            end else if (m_armed) begin
                if (s_start) m_ovr = 1;
                m_work = m_work | (s_stop & m_en);
                m_age++;
                if (m_work == m_en || m_age == TMO) begin
                    m_tflag     = (m_work != m_en);
                    m_hit       = m_work;
                    m_armed     = 0;
                    m_intr_left = ILEN;
                end
            end else if (s_start) begin
                m_armed = 1; m_age = 0; m_en = en_mask; m_work = '0;
            end
            for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {startpulse, stoppulse};
        end
    end

    int low_run = 0, last_low_len = 0, armed_run = 0, last_armed_len = 0, intr_events = 0;
    logic prev_intr_n = 1'b1;

    always @(negedge clk) begin
        if (seen_reset) begin
            chk("intr_n", intr_n, (m_intr_left > 0) ? 1'b0 : 1'b1);
            chk("hit_mask", hit_mask, m_hit);
            chk("timeout_flag", timeout_flag, m_tflag);
            chk("overrun", overrun, m_ovr);
            chk("busy", busy, (m_armed || m_intr_left > 0));
            if (intr_n === 1'b0) begin
                if (prev_intr_n === 1'b1) intr_events++;
                low_run++;
            end else if (low_run > 0) begin
                last_low_len = low_run;
                low_run = 0;
            end
            if (busy === 1'b1 && intr_n === 1'b1) armed_run++;
            else if (intr_n === 1'b0 && armed_run > 0) begin
                last_armed_len = armed_run;
                armed_run = 0;
            end else if (busy !== 1'b1) armed_run = 0;
            prev_intr_n = intr_n;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        startpulse = 1'b1;
        step(1);
        startpulse = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        step(5);
        while (busy && k < 400) begin
            step(1);
            k++;
        end
        chk(name, busy, 1'b0);
        step(4);
    endtask

    task automatic wait_low(input string name);
        int k;
        k = 0;
        while (intr_n && k < 100) begin
            step(1);
            k++;
        end
        chk(name, intr_n, 1'b0);
    endtask

    initial begin
        int ev;
        // T1: reset held with toggling inputs
        res_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            startpulse = 1'($urandom);
            stoppulse  = NSTOP'($urandom);
            en_mask    = NSTOP'($urandom);
            step(1);
        end
        chk("t1_intr_n", intr_n, 1'b1);
        chk("t1_hit", hit_mask, 8'h00);
        chk("t1_busy", busy, 1'b0);
        chk("t1_overrun", overrun, 1'b0);
        startpulse = 1'b0; stoppulse = '0; en_mask = '0;
        step(2);
        res_n = 1'b1;
        step(6);

        // T2: all stops, staggered
        en_mask = 8'hFF;
        pulse_start();
        for (int i = 0; i < NSTOP; i++) begin
            stoppulse = NSTOP'(1) << i;
            step(1);
            stoppulse = '0;
            step(1);
        end
        wait_idle("t2_idle");
        chk("t2_hit", hit_mask, 8'hFF);
        chk("t2_tflag", timeout_flag, 1'b0);
        chk("t2_low_len", last_low_len, ILEN);
        chk("t2_armed_len", last_armed_len, 15);

        // T3: partial hits, timeout
        en_mask = 8'h0F;
        pulse_start();
        step(2);
        stoppulse = 8'h01; step(1); stoppulse = '0; step(1);
        stoppulse = 8'h02; step(1); stoppulse = '0;
        wait_idle("t3_idle");
        chk("t3_hit", hit_mask, 8'h03);
        chk("t3_tflag", timeout_flag, 1'b1);
        chk("t3_armed_len", last_armed_len, TMO);
        chk("t3_low_len", last_low_len, ILEN);

        // T4: stop with start is ignored; stop in the last ARMED cycle beats timeout
        en_mask = 8'h01;
        startpulse = 1'b1; stoppulse = 8'h01;
        step(1);
        startpulse = 1'b0; stoppulse = '0;
        step(15);
        stoppulse = 8'h01;
        step(1);
        stoppulse = '0;
        wait_idle("t4_idle");
        chk("t4_hit", hit_mask, 8'h01);
        chk("t4_tflag", timeout_flag, 1'b0);
        chk("t4_armed_len", last_armed_len, TMO);

        // T5: overrun during ARMED and INTR; empty enable mask
        en_mask = 8'h03;
        pulse_start();
        step(6);
        pulse_start();
        wait_low("t5_low");
        step(10);
        pulse_start();
        wait_idle("t5_idle");
        chk("t5_overrun", overrun, 1'b1);
        chk("t5_hit", hit_mask, 8'h00);
        chk("t5_tflag", timeout_flag, 1'b1);
        chk("t5_armed_len", last_armed_len, TMO);
        en_mask = 8'h00;
        pulse_start();
        wait_idle("t5_idle0");
        chk("t5_armed_len0", last_armed_len, 1);
        chk("t5_hit0", hit_mask, 8'h00);
        chk("t5_tflag0", timeout_flag, 1'b0);
        chk("t5_overrun_sticky", overrun, 1'b1);

        // T6: reset mid-ARMED and mid-INTR
        en_mask = 8'hFF;
        pulse_start();
        step(6);
        ev = intr_events;
        res_n = 1'b0; step(1); res_n = 1'b1;
        chk("t6a_busy", busy, 1'b0);
        chk("t6a_intr_n", intr_n, 1'b1);
        chk("t6a_overrun", overrun, 1'b0);
        step(100);
        chk("t6a_no_intr", intr_events, ev);
        en_mask = 8'h00;
        pulse_start();
        wait_low("t6b_low");
        step(10);
        ev = intr_events;
        res_n = 1'b0; step(1); res_n = 1'b1;
        chk("t6b_busy", busy, 1'b0);
        chk("t6b_intr_n", intr_n, 1'b1);
        step(100);
        chk("t6b_no_intr", intr_events, ev);

        // Random pulses, enables and occasional resets
        for (int c = 0; c < 4000; c++) begin
            logic [NSTOP-1:0] s;
            s = '0;
            for (int b = 0; b < NSTOP; b++) s[b] = ($urandom_range(0, 15) == 0);
            stoppulse  = s;
            startpulse = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 19) == 0) en_mask = NSTOP'($urandom);
            res_n = ($urandom_range(0, 599) != 0);
            step(1);
        end
        res_n = 1'b1; startpulse = 1'b0; stoppulse = '0;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
